// File: rtl/alu_control_seq_if.sv
// Bundle between the ID/EX boundary and the ALU control sequencer.
// master: the upstream stage driving instructions; slave: the sequencer itself.
interface alu_control_seq_if #(
  parameter int unsigned OP_WIDTH = 5
) ();

  logic                valid_in;
  logic [2:0]          alu_op;
  logic [5:0]          alu_function;
  logic                flush;
  logic [OP_WIDTH-1:0] alu_operation;
  logic                valid_out;
  logic                jr_selector;
  logic                illegal;
  logic                md_start;
  logic                stall;
  logic                hilo_we;

  modport master (
    output valid_in,
    output alu_op,
    output alu_function,
    output flush,
    input  alu_operation,
    input  valid_out,
    input  jr_selector,
    input  illegal,
    input  md_start,
    input  stall,
    input  hilo_we
  );

  modport slave (
    input  valid_in,
    input  alu_op,
    input  alu_function,
    input  flush,
    output alu_operation,
    output valid_out,
    output jr_selector,
    output illegal,
    output md_start,
    output stall,
    output hilo_we
  );

endinterface

// File: rtl/alu_control_seq.sv
// Registered MIPS ALU control with multi-cycle MULT/DIV sequencing.
// Decodes ALUOp/funct into an operation code one cycle after acceptance and
// stalls upstream while the multiply/divide unit is busy.
module alu_control_seq #(
  parameter int unsigned OP_WIDTH    = 5,
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_control_seq_if.slave  bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntWidth  = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  // Counter loads N-1 so that BUSY spans exactly N cycles (N-1 down to 0).
  localparam logic [CntWidth-1:0] MultLoad = CntWidth'(MULT_CYCLES - 1);
  localparam logic [CntWidth-1:0] DivLoad  = CntWidth'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic [OP_WIDTH-1:0] op_q;
  logic                valid_q;
  logic                jr_q;
  logic                illegal_q;
  logic                md_start_q;

  logic [4:0]          dec_code;
  logic                dec_jr;
  logic                dec_illegal;
  logic                dec_mult;
  logic                dec_div;
  logic [OP_WIDTH-1:0] dec_op;

  logic                stall;
  logic                accept;

  assign stall  = (state_q == StBusy);
  // Flush discards anything presented alongside it; reset is handled by the registers.
  assign accept = bus.valid_in & ~stall & ~bus.flush;

  // Combinational decode of ALUOp/funct into a 5-bit code and side flags.
  always_comb begin
    dec_code    = 5'h1F;
    dec_jr      = 1'b0;
    dec_illegal = 1'b0;
    dec_mult    = 1'b0;
    dec_div     = 1'b0;
    case (bus.alu_op)
      3'b111: begin
        case (bus.alu_function)
          6'b100100: dec_code = 5'h00;  // AND
          6'b100101: dec_code = 5'h01;  // OR
          6'b100111: dec_code = 5'h02;  // NOR
          6'b100000: dec_code = 5'h03;  // ADD
          6'b100010: dec_code = 5'h04;  // SUB
          6'b000010: dec_code = 5'h05;  // SRL
          6'b000000: dec_code = 5'h06;  // SLL
          6'b101010: dec_code = 5'h0A;  // SLT
          6'b011000: begin              // MULT
            dec_code = 5'h0B;
            dec_mult = 1'b1;
          end
          6'b011010: begin              // DIV
            dec_code = 5'h0C;
            dec_div  = 1'b1;
          end
          6'b010000: dec_code = 5'h0D;  // MFHI
          6'b001000: begin              // JR
            dec_code = 5'h0E;
            dec_jr   = 1'b1;
          end
          6'b010010: dec_code = 5'h10;  // MFLO
          default:   dec_illegal = 1'b1;
        endcase
      end
      3'b100:  dec_code = 5'h03;  // ADDI
      3'b101:  dec_code = 5'h01;  // ORI
      3'b011:  dec_code = 5'h07;  // LUI
      3'b001:  dec_code = 5'h08;  // BEQ
      3'b010:  dec_code = 5'h09;  // BNE
      3'b110:  dec_code = 5'h03;  // SW
      3'b000:  dec_code = 5'h03;  // LW
      default: dec_code = 5'h1F;
    endcase
    // Illegal funct reports all-ones at full width, not just the low 5 bits.
    dec_op = dec_illegal ? {OP_WIDTH{1'b1}} : OP_WIDTH'(dec_code);
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and its countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      // Abandon any multi-cycle op; no HI/LO write will follow.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (accept && (dec_mult || dec_div)) begin
            state_d = StBusy;
            cnt_d   = dec_div ? DivLoad : MultLoad;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sequencer state and countdown registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered decode outputs; alu_operation holds when nothing is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= {OP_WIDTH{1'b1}};
      valid_q    <= 1'b0;
      jr_q       <= 1'b0;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
    end else begin
      valid_q    <= accept;
      jr_q       <= accept & dec_jr;
      illegal_q  <= accept & dec_illegal;
      md_start_q <= accept & (dec_mult | dec_div);
      if (accept) begin
        op_q <= dec_op;
      end
    end
  end

  assign bus.alu_operation = op_q;
  assign bus.valid_out     = valid_q;
  assign bus.jr_selector   = jr_q;
  assign bus.illegal       = illegal_q;
  assign bus.md_start      = md_start_q;
  assign bus.stall         = stall;
  assign bus.hilo_we       = (state_q == StDone);

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table, MULT/DIV sequencing,
// flush and reset interactions. Inputs driven and outputs sampled at negedge.
module tb_alu_control_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  alu_control_seq_if #(.OP_WIDTH(5)) bus ();

  alu_control_seq #(
    .OP_WIDTH   (5),
    .MULT_CYCLES(4),
    .DIV_CYCLES (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
    bus.valid_in     = v;
    bus.alu_op       = op;
    bus.alu_function = fn;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".op"},      32'(bus.alu_operation), 32'h1F);
    check_eq({tag, ".valid"},   32'(bus.valid_out),     32'd0);
    check_eq({tag, ".stall"},   32'(bus.stall),         32'd0);
    check_eq({tag, ".md"},      32'(bus.md_start),      32'd0);
    check_eq({tag, ".hilo"},    32'(bus.hilo_we),       32'd0);
    check_eq({tag, ".jr"},      32'(bus.jr_selector),   32'd0);
    check_eq({tag, ".illegal"}, 32'(bus.illegal),       32'd0);
  endtask

  task automatic dec_vec(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [4:0] code, input logic jr, input logic ill);
    drive(1'b1, op, fn);
    step();
    check_eq({tag, ".valid"},   32'(bus.valid_out),     32'd1);
    check_eq({tag, ".op"},      32'(bus.alu_operation), 32'(code));
    check_eq({tag, ".jr"},      32'(bus.jr_selector),   32'(jr));
    check_eq({tag, ".illegal"}, 32'(bus.illegal),       32'(ill));
    check_eq({tag, ".stall"},   32'(bus.stall),         32'd0);
  endtask

  initial begin
    int stall_cnt;
    int hilo_cnt;
    int first_hilo;
    int early;
    int found;

    bus.flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);

    // Reset held two cycles, then released with nothing presented.
    step();
    step();
    check_reset_vals("rst_hold");
    reset = 1'b0;
    step();
    check_reset_vals("rst_idle");

    // Decode table.
    dec_vec("add",   3'b111, 6'b100000, 5'h03, 1'b0, 1'b0);
    dec_vec("addi",  3'b100, 6'b111111, 5'h03, 1'b0, 1'b0);
    dec_vec("jr",    3'b111, 6'b001000, 5'h0E, 1'b1, 1'b0);
    dec_vec("ill",   3'b111, 6'b111111, 5'h1F, 1'b0, 1'b1);
    dec_vec("and",   3'b111, 6'b100100, 5'h00, 1'b0, 1'b0);
    dec_vec("or",    3'b111, 6'b100101, 5'h01, 1'b0, 1'b0);
    dec_vec("nor",   3'b111, 6'b100111, 5'h02, 1'b0, 1'b0);
    dec_vec("sub",   3'b111, 6'b100010, 5'h04, 1'b0, 1'b0);
    dec_vec("srl",   3'b111, 6'b000010, 5'h05, 1'b0, 1'b0);
    dec_vec("sll",   3'b111, 6'b000000, 5'h06, 1'b0, 1'b0);
    dec_vec("slt",   3'b111, 6'b101010, 5'h0A, 1'b0, 1'b0);
    dec_vec("mfhi",  3'b111, 6'b010000, 5'h0D, 1'b0, 1'b0);
    dec_vec("ori",   3'b101, 6'b100000, 5'h01, 1'b0, 1'b0);
    dec_vec("lui",   3'b011, 6'b000000, 5'h07, 1'b0, 1'b0);
    dec_vec("beq",   3'b001, 6'b001000, 5'h08, 1'b0, 1'b0);
    dec_vec("bne",   3'b010, 6'b011000, 5'h09, 1'b0, 1'b0);
    dec_vec("sw",    3'b110, 6'b010000, 5'h03, 1'b0, 1'b0);
    dec_vec("lw",    3'b000, 6'b111111, 5'h03, 1'b0, 1'b0);
    dec_vec("mflo",  3'b111, 6'b010010, 5'h10, 1'b0, 1'b0);

    // No acceptance: flags clear, operation code holds.
    drive(1'b0, 3'b111, 6'b001000);
    step();
    check_eq("hold.valid", 32'(bus.valid_out),     32'd0);
    check_eq("hold.jr",    32'(bus.jr_selector),   32'd0);
    check_eq("hold.op",    32'(bus.alu_operation), 32'h10);

    // MULT with ADD held behind it.
    drive(1'b1, 3'b111, 6'b011000);
    step();  // T1
    check_eq("mult.t1.md",    32'(bus.md_start),      32'd1);
    check_eq("mult.t1.op",    32'(bus.alu_operation), 32'h0B);
    check_eq("mult.t1.valid", 32'(bus.valid_out),     32'd1);
    check_eq("mult.t1.stall", 32'(bus.stall),         32'd1);
    drive(1'b1, 3'b111, 6'b100000);
    for (int t = 2; t <= 4; t++) begin
      step();
      check_eq("mult.busy.stall", 32'(bus.stall),     32'd1);
      check_eq("mult.busy.md",    32'(bus.md_start),  32'd0);
      check_eq("mult.busy.valid", 32'(bus.valid_out), 32'd0);
      check_eq("mult.busy.hilo",  32'(bus.hilo_we),   32'd0);
    end
    step();  // T5
    check_eq("mult.t5.stall", 32'(bus.stall),     32'd0);
    check_eq("mult.t5.hilo",  32'(bus.hilo_we),   32'd1);
    check_eq("mult.t5.valid", 32'(bus.valid_out), 32'd0);
    step();  // T6
    check_eq("mult.t6.valid", 32'(bus.valid_out),     32'd1);
    check_eq("mult.t6.op",    32'(bus.alu_operation), 32'h03);
    check_eq("mult.t6.hilo",  32'(bus.hilo_we),       32'd0);
    drive(1'b0, 3'b000, 6'b000000);
    step();

    // MULT then MFHI held: MFHI accepted in the DONE cycle.
    drive(1'b1, 3'b111, 6'b011000);
    step();  // T1
    drive(1'b1, 3'b111, 6'b010000);
    found = 0;
    for (int c = 2; c <= 12; c++) begin
      if (found == 0) begin
        step();
        if (bus.valid_out === 1'b1) found = c;
      end
    end
    check_eq("mfhi.cycle", 32'(found),             32'd6);
    check_eq("mfhi.op",    32'(bus.alu_operation), 32'h0D);
    drive(1'b0, 3'b000, 6'b000000);
    step();

    // Flush in the last BUSY cycle suppresses the HI/LO write.
    drive(1'b1, 3'b111, 6'b011000);
    step();  // T1
    drive(1'b0, 3'b000, 6'b000000);
    repeat (3) step();  // T4
    bus.flush = 1'b1;
    step();  // T5
    bus.flush = 1'b0;
    check_eq("flz.hilo",  32'(bus.hilo_we), 32'd0);
    check_eq("flz.stall", 32'(bus.stall),   32'd0);
    step();
    check_eq("flz.hilo2", 32'(bus.hilo_we), 32'd0);

    // DIV with ADD held: 32 stall cycles, single hilo_we at T33.
    drive(1'b1, 3'b111, 6'b011010);
    step();  // T1
    drive(1'b1, 3'b111, 6'b100000);
    stall_cnt  = 0;
    hilo_cnt   = 0;
    first_hilo = 0;
    early      = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.stall === 1'b1) stall_cnt++;
      if (bus.hilo_we === 1'b1) begin
        hilo_cnt++;
        if (first_hilo == 0) first_hilo = cyc;
      end
      if (cyc >= 2 && cyc <= 33 && bus.valid_out === 1'b1) early++;
      step();
    end
    drive(1'b0, 3'b000, 6'b000000);
    step();
    check_eq("div.stall_cycles", 32'(stall_cnt),  32'd32);
    check_eq("div.hilo_cycle",   32'(first_hilo), 32'd33);
    check_eq("div.hilo_pulses",  32'(hilo_cnt),   32'd1);
    check_eq("div.early_accept", 32'(early),      32'd0);

    // DIV flushed at T10 along with a presented ADD.
    drive(1'b1, 3'b111, 6'b011010);
    step();  // T1
    drive(1'b0, 3'b000, 6'b000000);
    repeat (9) step();  // T10
    bus.flush = 1'b1;
    drive(1'b1, 3'b111, 6'b100000);
    step();  // T11
    bus.flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);
    check_eq("dfl.stall", 32'(bus.stall),     32'd0);
    check_eq("dfl.valid", 32'(bus.valid_out), 32'd0);
    check_eq("dfl.hilo",  32'(bus.hilo_we),   32'd0);
    stall_cnt = 0;
    hilo_cnt  = 0;
    repeat (40) begin
      step();
      if (bus.stall === 1'b1) stall_cnt++;
      if (bus.hilo_we === 1'b1) hilo_cnt++;
    end
    check_eq("dfl.stall_after", 32'(stall_cnt), 32'd0);
    check_eq("dfl.hilo_after",  32'(hilo_cnt),  32'd0);

    // Reset mid-BUSY aborts the MULT.
    drive(1'b1, 3'b111, 6'b011000);
    step();  // T1
    drive(1'b0, 3'b000, 6'b000000);
    step();  // T2
    reset = 1'b1;
    step();
    check_reset_vals("rst_busy");
    reset = 1'b0;
    hilo_cnt = 0;
    repeat (8) begin
      step();
      if (bus.hilo_we === 1'b1) hilo_cnt++;
    end
    check_eq("rst_busy.hilo_after", 32'(hilo_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, sequencing ALU control unit for the MIPS datapath.
- Decodes ALUOp from the main control and the funct field into an ALU operation code, JR select and illegal flag, with one cycle of latency.
- Adds multi-cycle MULT/DIV support: a countdown stall, an HI/LO write strobe, MFHI/MFLO decode and a pipeline flush.
- Sits between the ID/EX boundary and the ALU / multiply-divide unit.

Parameters:
- OP_WIDTH, 5, width of alu_operation; must be >= 5.
- MULT_CYCLES, 4, cycles the multiply unit needs after md_start; must be >= 1.
- DIV_CYCLES, 32, cycles the divide unit needs after md_start; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  alu_op/alu_function carry an instruction this cycle.
- alu_op  input  3  main-control ALUOp.
- alu_function  input  6  instruction funct field.
- flush  input  1  synchronous kill of in-flight and incoming work.
- alu_operation  output  OP_WIDTH  registered operation code.
- valid_out  output  1  alu_operation/jr_selector/illegal valid this cycle.
- jr_selector  output  1  registered; high with valid_out for JR.
- illegal  output  1  registered; high with valid_out for an undecodable R-type funct.
- md_start  output  1  one-cycle pulse launching MULT/DIV.
- stall  output  1  high while a multi-cycle op is busy; upstream holds inputs.
- hilo_we  output  1  one-cycle HI/LO write strobe at MULT/DIV completion.

Behaviour:
- Decode, ALUOp 3'b111 (R-type), by funct → code:
  - 100100 AND → 0x00; 100101 OR → 0x01; 100111 NOR → 0x02; 100000 ADD → 0x03; 100010 SUB → 0x04.
  - 000010 SRL → 0x05; 000000 SLL → 0x06; 101010 SLT → 0x0A; 011000 MULT → 0x0B; 011010 DIV → 0x0C.
  - 010000 MFHI → 0x0D; 001000 JR → 0x0E (jr_selector=1); 010010 MFLO → 0x10.
  - Any other funct → all-ones, illegal=1.
- Decode, other ALUOp values (funct ignored): 100 ADDI → 0x03; 101 ORI → 0x01; 011 LUI → 0x07; 001 BEQ → 0x08; 010 BNE → 0x09; 110 SW → 0x03; 000 LW → 0x03.
- Codes are zero-extended to OP_WIDTH.
- Acceptance: an instruction is accepted at a rising edge where valid_in=1, stall=0, flush=0 and reset=0. Inputs while stall=1 are ignored, not queued.
- Latency: all decoded outputs and valid_out are registered and appear the cycle after acceptance. Without acceptance: valid_out=0, jr_selector=0, illegal=0; alu_operation holds its last value.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on accepting MULT or DIV, next cycle valid_out=1, md_start=1, stall=1, state=BUSY. The counter loads MULT_CYCLES-1 or DIV_CYCLES-1 respectively.
  - BUSY: stall=1. The counter decrements each cycle; when it reads 0, next state is DONE. BUSY therefore lasts exactly MULT_CYCLES / DIV_CYCLES cycles.
  - DONE: one cycle with hilo_we=1 and stall=0; a new instruction may be accepted this cycle. Next state is IDLE, or BUSY if that instruction is MULT/DIV.
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)), minimum 1; no wrap-around reachable.
- Flush (priority below reset):
  - Next cycle valid_out=0, md_start=0, hilo_we=0, illegal=0, jr_selector=0.
  - Any BUSY/DONE returns to IDLE with no hilo_we; an instruction presented with flush is discarded.
- Reset values: state IDLE, counter 0, alu_operation all-ones, all other outputs 0. Reset mid-BUSY aborts with no hilo_we.
- Simultaneous events: reset > flush > acceptance. The counter reaching 0 while flush is asserted yields no hilo_we.

Test Plan:
- Reset held 2 cycles then released, no valid_in → alu_operation=0x1F, valid_out=stall=md_start=hilo_we=0.
- valid_in with alu_op=111, funct=100000, then alu_op=100 → consecutive cycles valid_out=1, alu_operation=0x03 and 0x03, stall=0. funct=001000 → 0x0E with jr_selector=1. funct=111111 → 0x1F with illegal=1.
- MULT (111/011000) accepted at T0, valid_in held high with ADD:
  - T1: md_start=1, alu_operation=0x0B.
  - stall high T1–T4.
  - T5: hilo_we=1 and ADD accepted; T6: valid_out=1, alu_operation=0x03.
- DIV accepted at T0 → stall high exactly 32 cycles. hilo_we appears only at T33; no second acceptance before T33.
- DIV accepted, flush pulsed at T10 → from T11 stall=0, state IDLE; hilo_we never asserts; valid_out=0 at T11.
- MULT, then MFHI held on valid_in → MFHI accepted in the DONE cycle, next cycle alu_operation=0x0D. Reset asserted mid-BUSY → next cycle all outputs at reset values, hilo_we never pulses.
